// File: rtl/fetch_prefetch_unit_if.sv
// Bus bundle for the fetch/prefetch unit: the instruction-memory request and
// response channels plus the {pc, instruction} handshake towards decode.
// The master modport is the fetch unit; the slave modport is its environment
// (memory on one side, decode on the other).
interface fetch_prefetch_unit_if #(
  parameter int AW = 32,
  parameter int IW = 32
);
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [IW-1:0] imem_rsp_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [IW-1:0] out_instr;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output out_valid, out_pc, out_instr,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  out_valid, out_pc, out_instr,
    output out_ready
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage with a DEPTH-entry prefetch queue in front of decode.
// Requests go out to an in-order, arbitrary-latency instruction memory; the
// PC of every live request waits in a tag FIFO until its response arrives.
// A redirect flushes everything and turns the requests still in flight into
// responses that must be dropped (drop_cnt).
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_stall / perf_redirect.
module fetch_prefetch_unit #(
  parameter int            AW       = 32,
  parameter int            IW       = 32,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] PC_STEP  = AW'(1),
  parameter logic [AW-1:0] RESET_PC = AW'(0)
) (
  input  logic                     clk,
  input  logic                     rst,
  fetch_prefetch_unit_if.master    bus,
  input  logic                     redirect_valid,
  input  logic [AW-1:0]            redirect_pc,
  input  logic                     halt,
  output logic [$clog2(DEPTH):0]   queue_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_stall,
  output logic [31:0]              perf_redirect
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;
  // Stale responses can pile up across back-to-back redirects, so the drop
  // counter is much wider than the live-request counter.
  localparam int DW = 16;

  logic [AW-1:0] fetch_pc;

  logic [AW-1:0] tag_mem [DEPTH];
  logic [PW-1:0] tag_wr;
  logic [PW-1:0] tag_rd;

  logic [AW-1:0] q_pc    [DEPTH];
  logic [IW-1:0] q_instr [DEPTH];
  logic [PW-1:0] q_wr;
  logic [PW-1:0] q_rd;
  logic [CW-1:0] q_count;

  logic [CW-1:0] outstanding;
  logic [DW-1:0] drop_cnt;

  logic          credit_ok;
  logic          req_valid;
  logic          req_fire;
  logic          rsp_drop;
  logic          rsp_take;
  logic          out_valid;
  logic          out_fire;
  logic [DW-1:0] pending_all;
  logic [DW-1:0] redirect_drop;

  // Handshake decode; credit only looks at registered occupancy so a pop in
  // this cycle never buys an extra request.
  always_comb begin
    credit_ok     = ({1'b0, q_count} + {1'b0, outstanding}) < SW'(DEPTH);
    req_valid     = !rst && !halt && !redirect_valid && credit_ok;
    req_fire      = req_valid && bus.imem_req_ready;
    rsp_drop      = bus.imem_rsp_valid && (drop_cnt != '0);
    rsp_take      = bus.imem_rsp_valid && (drop_cnt == '0) && (outstanding != '0);
    out_valid     = (q_count != '0);
    out_fire      = out_valid && bus.out_ready;
    pending_all   = drop_cnt + DW'(outstanding);
    redirect_drop = (bus.imem_rsp_valid && (pending_all != '0)) ? pending_all - 1'b1
                                                                : pending_all;
  end

  // Control state: PC, FIFO pointers and counters, with redirect flushing all.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      tag_wr      <= '0;
      tag_rd      <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      q_count     <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_pc;
      tag_wr      <= '0;
      tag_rd      <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      q_count     <= '0;
      outstanding <= '0;
      drop_cnt    <= redirect_drop;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + PC_STEP;
        tag_wr   <= tag_wr + 1'b1;
      end
      if (rsp_take) begin
        tag_rd <= tag_rd + 1'b1;
        q_wr   <= q_wr + 1'b1;
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
      if (out_fire) begin
        q_rd <= q_rd + 1'b1;
      end
      q_count     <= q_count + CW'(rsp_take) - CW'(out_fire);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
    end
  end

  // Storage: tag of each issued request, then {tag, data} once it returns.
  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid) begin
      if (req_fire) begin
        tag_mem[tag_wr] <= fetch_pc;
      end
      if (rsp_take) begin
        q_pc[q_wr]    <= tag_mem[tag_rd];
        q_instr[q_wr] <= bus.imem_rsp_data;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched  <= '0;
      perf_stall    <= '0;
      perf_redirect <= '0;
    end else begin
      if (out_fire) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (bus.out_ready && !out_valid) begin
        perf_stall <= perf_stall + 32'd1;
      end
      if (redirect_valid) begin
        perf_redirect <= perf_redirect + 32'd1;
      end
    end
  end
`endif

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.out_valid      = out_valid;
  assign bus.out_pc         = q_pc[q_rd];
  assign bus.out_instr      = q_instr[q_rd];
  assign queue_count        = q_count;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Testbench for fetch_prefetch_unit: a reference-vector table for the
// reset/streaming/backpressure timeline, hand-written redirect/halt/reset
// sequences, and a randomized run against a queue-based reference model.
module tb_fetch_prefetch_unit;

  localparam int AW       = 32;
  localparam int IW       = 32;
  localparam int DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst;
  logic redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic halt;
  logic [$clog2(DEPTH):0] queue_count;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, perf_redirect;
  logic [31:0] m_fetched, m_stall, m_redirect;
`endif

  fetch_prefetch_unit_if #(.AW(AW), .IW(IW)) bus ();

  fetch_prefetch_unit #(
    .AW(AW), .IW(IW), .DEPTH(DEPTH), .PC_STEP(32'd1), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halt(halt),
    .queue_count(queue_count)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall(perf_stall),
    .perf_redirect(perf_redirect)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          due;
    bit          stale;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    bit rst;
    bit out_ready;
    bit exp_valid;
    int exp_pc;
    int exp_count;
    bit exp_req;
  } vec_t;

  pend_t pend[$];
  ent_t  mq[$];
  logic [31:0] m_pc;
  bit    m_known;
  int    cyc;
  int    n_cmp;
  int    n_bad;

  bit drv_rst, drv_out_ready, drv_req_ready, drv_halt, drv_redirect;
  logic [31:0] drv_redirect_pc;
  int lat_min, lat_max;

  bit exp_valid, exp_req;
  int req_fires;
  logic [31:0] last_req_addr, last_out_pc;

  vec_t tbl[26];

  // Memory contents: a fixed hash of the address.
  function automatic logic [31:0] memf(input logic [31:0] pc);
    logic [31:0] h;
    h = pc * 32'h9E37_79B1;
    return h ^ 32'h5A5A_1234 ^ {pc[15:0], pc[31:16]};
  endfunction

  function automatic int live_count();
    int n = 0;
    foreach (pend[i]) if (!pend[i].stale) n++;
    return n;
  endfunction

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus();
    rst            = drv_rst;
    halt           = drv_halt;
    redirect_valid = drv_redirect;
    redirect_pc    = drv_redirect_pc;
    bus.out_ready      = drv_out_ready;
    bus.imem_req_ready = drv_req_ready;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memf(pend[0].pc);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
  endtask

  task automatic checkOutput();
    if (!m_known) return;
    compare("out_valid", bus.out_valid, exp_valid);
    compare("queue_count", queue_count, mq.size());
    compare("queue_bound", (int'(queue_count) <= DEPTH), 1);
    compare("req_valid", bus.imem_req_valid, exp_req);
    if (exp_valid) begin
      compare("out_pc", bus.out_pc, mq[0].pc);
      compare("out_instr", bus.out_instr, mq[0].instr);
    end
    if (exp_req) compare("req_addr", bus.imem_req_addr, m_pc);
`ifdef FETCH_PERF_EN
    compare("perf_fetched", perf_fetched, m_fetched);
    compare("perf_stall", perf_stall, m_stall);
    compare("perf_redirect", perf_redirect, m_redirect);
`endif
  endtask

  task automatic updateModel();
    bit    rsp_v;
    pend_t p;
    rsp_v = bus.imem_rsp_valid;
    if (drv_rst) begin
      pend.delete();
      mq.delete();
      m_pc    = RESET_PC;
      m_known = 1'b1;
`ifdef FETCH_PERF_EN
      m_fetched = 0; m_stall = 0; m_redirect = 0;
`endif
    end else begin
`ifdef FETCH_PERF_EN
      if (exp_valid && drv_out_ready) m_fetched++;
      if (drv_out_ready && !exp_valid) m_stall++;
      if (drv_redirect) m_redirect++;
`endif
      if (drv_redirect) begin
        if (rsp_v) void'(pend.pop_front());
        foreach (pend[i]) pend[i].stale = 1'b1;
        mq.delete();
        m_pc = drv_redirect_pc;
      end else begin
        if (exp_valid && drv_out_ready) void'(mq.pop_front());
        if (rsp_v) begin
          p = pend.pop_front();
          if (!p.stale) mq.push_back('{p.pc, memf(p.pc)});
        end
        if (exp_req && drv_req_ready) begin
          pend.push_back('{m_pc, cyc + int'($urandom_range(lat_max, lat_min)), 1'b0});
          m_pc = m_pc + 32'd1;
        end
      end
    end
  endtask

  task automatic preEdge();
    applyStimulus();
    #1;
    exp_valid = (mq.size() > 0);
    exp_req   = !drv_rst && !drv_halt && !drv_redirect && ((mq.size() + live_count()) < DEPTH);
    checkOutput();
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      req_fires++;
      last_req_addr = bus.imem_req_addr;
    end
    if (bus.out_valid && bus.out_ready) last_out_pc = bus.out_pc;
  endtask

  task automatic postEdge();
    @(posedge clk);
    updateModel();
    cyc++;
    @(negedge clk);
  endtask

  task automatic tick();
    preEdge();
    postEdge();
  endtask

  task automatic doReset();
    drv_rst = 1'b1; drv_redirect = 1'b0; drv_halt = 1'b0;
    tick();
    drv_rst = 1'b0;
  endtask

  task automatic waitOutValid();
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    compare("wait_out_valid", bus.out_valid, 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fires_before;
    n_cmp = 0; n_bad = 0; cyc = 0; m_known = 1'b0; m_pc = RESET_PC;
    req_fires = 0; last_req_addr = '0; last_out_pc = '0;
`ifdef FETCH_PERF_EN
    m_fetched = 0; m_stall = 0; m_redirect = 0;
`endif
    drv_rst = 1'b1; drv_out_ready = 1'b1; drv_req_ready = 1'b1;
    drv_halt = 1'b0; drv_redirect = 1'b0; drv_redirect_pc = '0;
    lat_min = 1; lat_max = 1;

    // Reference timeline: stream from reset, reset again, then backpressure.
    tbl[0]  = '{0, 1, 0, 0, 0, 1};
    tbl[1]  = '{0, 1, 0, 0, 0, 1};
    tbl[2]  = '{0, 1, 1, 0, 1, 1};
    tbl[3]  = '{0, 1, 1, 1, 1, 1};
    tbl[4]  = '{0, 1, 1, 2, 1, 1};
    tbl[5]  = '{0, 1, 1, 3, 1, 1};
    tbl[6]  = '{0, 1, 1, 4, 1, 1};
    tbl[7]  = '{0, 1, 1, 5, 1, 1};
    tbl[8]  = '{1, 1, 1, 6, 1, 0};
    tbl[9]  = '{1, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 1};
    tbl[12] = '{0, 0, 1, 0, 1, 1};
    tbl[13] = '{0, 0, 1, 0, 2, 1};
    tbl[14] = '{0, 0, 1, 0, 3, 0};
    for (int i = 15; i < 20; i++) tbl[i] = '{0, 0, 1, 0, 4, 0};
    tbl[20] = '{0, 1, 1, 0, 4, 0};
    tbl[21] = '{0, 1, 1, 1, 3, 1};
    tbl[22] = '{0, 1, 1, 2, 2, 1};
    tbl[23] = '{0, 1, 1, 3, 2, 1};
    tbl[24] = '{0, 1, 1, 4, 2, 1};
    tbl[25] = '{0, 1, 1, 5, 2, 1};

    $display("[TB] reset and reference timeline");
    doReset();
    compare("reset_req_addr", bus.imem_req_addr, RESET_PC);
    compare("reset_out_valid", bus.out_valid, 0);
    for (int i = 0; i < 26; i++) begin
      drv_rst       = tbl[i].rst;
      drv_out_ready = tbl[i].out_ready;
      preEdge();
      compare("tbl_out_valid", bus.out_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) compare("tbl_out_pc", bus.out_pc, tbl[i].exp_pc);
      compare("tbl_queue_count", queue_count, tbl[i].exp_count);
      compare("tbl_req_valid", bus.imem_req_valid, tbl[i].exp_req);
      postEdge();
    end

    $display("[TB] redirect with two stale requests in flight");
    drv_out_ready = 1'b1; drv_req_ready = 1'b1; lat_min = 3; lat_max = 3;
    doReset();
    tick();
    tick();
    drv_redirect = 1'b1; drv_redirect_pc = 32'h100;
    tick();
    drv_redirect = 1'b0;
    waitOutValid();
    compare("redir_first_pc", bus.out_pc, 32'h100);
    tick();
    waitOutValid();
    compare("redir_second_pc", bus.out_pc, 32'h101);
    compare("redir_second_instr", bus.out_instr, memf(32'h101));

    $display("[TB] redirect together with handshake and response");
    lat_min = 1; lat_max = 1;
    doReset();
    for (int i = 0; i < 4; i++) tick();
    drv_redirect = 1'b1; drv_redirect_pc = 32'h200;
    tick();
    drv_redirect = 1'b0;
    compare("redir_hs_count", queue_count, 0);
    compare("redir_hs_valid", bus.out_valid, 0);
    waitOutValid();
    compare("redir_hs_pc", bus.out_pc, 32'h200);

    $display("[TB] halt at fetch_pc 7");
    doReset();
    for (int n = 0; n < 50 && m_pc != 32'd7; n++) tick();
    compare("halt_fetch_pc", bus.imem_req_addr, 32'd7);
    drv_halt = 1'b1;
    fires_before = req_fires;
    for (int i = 0; i < 8; i++) tick();
    compare("halt_no_requests", req_fires - fires_before, 0);
    compare("halt_drained", queue_count, 0);
    compare("halt_last_out_pc", last_out_pc, 32'd6);
    drv_halt = 1'b0;
    fires_before = req_fires;
    tick();
    compare("halt_resume_count", req_fires - fires_before, 1);
    compare("halt_resume_addr", last_req_addr, 32'd7);

    $display("[TB] reset with three requests outstanding");
    lat_min = 3; lat_max = 3;
    doReset();
    for (int i = 0; i < 3; i++) tick();
    drv_rst = 1'b1;
    tick();
    compare("rst_out_valid", bus.out_valid, 0);
    compare("rst_queue_count", queue_count, 0);
    compare("rst_req_valid", bus.imem_req_valid, 0);
    compare("rst_req_addr", bus.imem_req_addr, RESET_PC);
`ifdef FETCH_PERF_EN
    compare("rst_perf_fetched", perf_fetched, 0);
    compare("rst_perf_stall", perf_stall, 0);
    compare("rst_perf_redirect", perf_redirect, 0);
`endif
    drv_rst = 1'b0;
    waitOutValid();
    compare("rst_restart_pc", bus.out_pc, RESET_PC);

    $display("[TB] randomized run against reference model");
    lat_min = 1; lat_max = 4;
    doReset();
    for (int i = 0; i < 3000; i++) begin
      drv_out_ready = ($urandom % 10) < 7;
      drv_req_ready = ($urandom % 4) != 0;
      if ($urandom % 20 == 0) drv_halt = !drv_halt;
      drv_redirect    = ($urandom % 30) == 0;
      drv_redirect_pc = ($urandom % 4 == 0) ? 32'hFFFF_FFFE : $urandom;
      drv_rst         = ($urandom % 400) == 0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
